// File: rtl/cpu_fetch_unit_pkg.sv
// rtl/cpu_fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package cpu_fetch_unit_pkg;

    localparam int unsigned CPU_XLEN     = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]         instr;
        logic [CPU_XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// rtl/cpu_fetch_unit_if.sv - instruction-memory request/response bus
//   imem_req_vld/imem_req_addr/imem_req_rdy : in-order fetch requests
//   imem_rsp_vld/imem_rsp_data              : in-order read data, latency >= 1
//   master = fetch unit, slave = instruction memory
interface cpu_fetch_unit_if
    import cpu_fetch_unit_pkg::*;
#(
    parameter int XLEN = CPU_XLEN
) ();

    logic            imem_req_vld;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_rdy;
    logic            imem_rsp_vld;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_vld, imem_req_addr,
        input  imem_req_rdy, imem_rsp_vld, imem_rsp_data
    );

    modport slave (
        input  imem_req_vld, imem_req_addr,
        output imem_req_rdy, imem_rsp_vld, imem_rsp_data
    );

endinterface

// File: rtl/cpu_fetch_unit_fifo.sv
// rtl/cpu_fetch_unit_fifo.sv - prefetch FIFO of fetch packets
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empties the FIFO next cycle (wins over push/pop)
//   push, push_data : write one packet (ignored when full)
//   pop             : drop the head packet (ignored when empty)
//   head            : registered head packet, valid when !empty
//   empty, full     : status
//   count           : occupancy, 0..DEPTH
module cpu_fetch_fifo
    import cpu_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  fetch_pkt_t push_data,
    input  logic       pop,
    output fetch_pkt_t head,
    output logic       empty,
    output logic       full,
    output logic [AW:0] count
);

    fetch_pkt_t    mem_q [DEPTH];
    // Pointers carry one extra MSB so full and empty differ when the low bits match.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - RV32I fetch stage: PC, imem requests, prefetch buffer, decode handshake
//   clk, rst                 : clock, synchronous active-high reset
//   imem (master)            : instruction-memory request/response bus
//   redirect_en, redirect_pc : taken branch/jump from execute, flushes and restarts fetch
//   if_vld, id_rdy           : handshake to decode
//   if_instr, if_pc, if_pc_plus4 : packet to decode (NOP/0/0 when if_vld=0)
module cpu_fetch_unit
    import cpu_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_VECTOR),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    cpu_fetch_unit_if.master imem,
    input  logic             redirect_en,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_vld,
    input  logic             id_rdy,
    output logic [31:0]      if_instr,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_pc_plus4
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;   // all outstanding requests, stale ones included
    logic [CW-1:0]   drop_q, drop_d;           // how many of those belong to a redirected-away stream
    logic [XLEN-1:0] tag_q [FIFO_DEPTH];       // PCs of live outstanding requests, oldest first
    logic [TW-1:0]   tag_wr_q, tag_wr_d;
    logic [TW-1:0]   tag_rd_q, tag_rd_d;

    logic            req_xfer, rsp_keep;
    logic [CW:0]     credit_used;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]   fifo_cnt;
    fetch_pkt_t      fifo_head, push_pkt;

    // Credits count buffered entries plus everything in flight, so every response
    // has a FIFO slot reserved; depends only on registered state, never on id_rdy.
    assign credit_used        = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign imem.imem_req_vld  = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem.imem_req_addr = pc_q;

    assign req_xfer = imem.imem_req_vld && imem.imem_req_rdy;
    assign rsp_keep = imem.imem_rsp_vld && (drop_q == '0);

    assign push_pkt.instr = imem.imem_rsp_data;
    assign push_pkt.pc    = tag_q[tag_rd_q];
    assign fifo_push      = rsp_keep && !redirect_en;
    assign fifo_pop       = if_vld && id_rdy && !redirect_en;

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        inflight_d = inflight_q + CW'(req_xfer) - CW'(imem.imem_rsp_vld);
        if (redirect_en) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            pc_d     = redirect_pc & ~XLEN'(3);
            drop_d   = inflight_d;
            tag_wr_d = '0;
            tag_rd_d = '0;
        end else begin
            if (req_xfer) begin
                pc_d     = pc_q + XLEN'(4);
                tag_wr_d = tag_wr_q + TW'(1);
            end
            if (imem.imem_rsp_vld) begin
                if (drop_q != '0) drop_d   = drop_q - CW'(1);
                else              tag_rd_d = tag_rd_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_xfer && !redirect_en) tag_q[tag_wr_q] <= pc_q;
    end

    cpu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push      (fifo_push),
        .push_data (push_pkt),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_cnt)
    );

    assign if_vld      = !fifo_empty;
    assign if_instr    = if_vld ? fifo_head.instr : INSTR_NOP;
    assign if_pc       = if_vld ? fifo_head.pc : '0;
    assign if_pc_plus4 = if_vld ? fifo_head.pc + XLEN'(4) : '0;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule
